// File: rtl/gate_array_bist.sv
// Gate array with a built-in exhaustive self-test. Each channel applies op to K
// inputs; the BIST sweeps every channel through all 2^K patterns against a golden model.

module gate_lane #(
    parameter int K = 2
) (
    input  logic [1:0]   op,
    input  logic [K-1:0] in,
    input  logic         inv,
    output logic         out
);
    logic r;

    always_comb begin
        r = 1'b0;
        unique case (op)
            2'b00: r = &in;
            2'b01: r = ~&in;
            2'b10: r = |in;
            2'b11: r = ~|in;
            default: r = 1'b0;
        endcase
        out = r ^ inv;
    end
endmodule

module gate_array_bist #(
    parameter int CH = 4,
    parameter int K  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      op,
    input  logic [CH*K-1:0] a,
    input  logic [CH-1:0]   fault_inj,
    input  logic            start,
    output logic [CH-1:0]   y,
    output logic            busy,
    output logic            done,
    output logic [15:0]     test_count,
    output logic [15:0]     error_count
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]             state;
    logic [1:0]             op_q;
    logic [CW-1:0]          ch;
    logic [K-1:0]           pat;
    logic [CH-1:0][K-1:0]   a_v;
    logic [CH-1:0][K-1:0]   core_in;
    logic [CH-1:0]          core_y;
    logic [1:0]             core_op;
    logic                   applying;
    logic                   golden;
    logic                   mismatch;
    logic                   last_pat;
    logic                   last_ch;

    assign a_v      = a;
    assign applying = (state == S_APPLY);
    assign core_op  = applying ? op_q : op;
    assign busy     = (state == S_APPLY) || (state == S_CHECK);

    // During APPLY only the channel under test sees the pattern; the rest idle at 0.
    for (genvar c = 0; c < CH; c++) begin : g_lane
        assign core_in[c] = applying ? ((ch == CW'(c)) ? pat : '0) : a_v[c];
        gate_lane #(.K(K)) u_lane (
            .op  (core_op),
            .in  (core_in[c]),
            .inv (fault_inj[c]),
            .out (core_y[c])
        );
    end

    // Golden reference built from pattern comparisons, not from the lane gates.
    always_comb begin
        golden = 1'b0;
        unique case (op_q)
            2'b00: golden = (pat == {K{1'b1}});
            2'b01: golden = (pat != {K{1'b1}});
            2'b10: golden = (pat != '0);
            2'b11: golden = (pat == '0);
            default: golden = 1'b0;
        endcase
    end

    assign mismatch = (y[ch] != golden);
    assign last_pat = (pat == {K{1'b1}});
    assign last_ch  = (ch == CW'(CH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            y           <= '0;
            done        <= 1'b0;
            test_count  <= '0;
            error_count <= '0;
            ch          <= '0;
            pat         <= '0;
            op_q        <= 2'b00;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    y <= core_y;
                    if (start) begin
                        state       <= S_APPLY;
                        op_q        <= op;
                        ch          <= '0;
                        pat         <= '0;
                        test_count  <= '0;
                        error_count <= '0;
                        done        <= 1'b0;
                    end else if (state == S_DONE) begin
                        state <= S_IDLE;
                    end
                end
                S_APPLY: begin
                    y     <= core_y;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (test_count != 16'hFFFF)
                        test_count <= test_count + 16'd1;
                    if (mismatch && error_count != 16'hFFFF)
                        error_count <= error_count + 16'd1;
                    if (!last_pat) begin
                        pat   <= pat + 1'b1;
                        state <= S_APPLY;
                    end else if (!last_ch) begin
                        pat   <= '0;
                        ch    <= ch + 1'b1;
                        state <= S_APPLY;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_array_bist.sv
// Bench for gate_array_bist: functional vector table plus self-test sequences
// (fault injection, restart while busy, mid-test reset, CH=2/K=3 instance).

module tb_gate_array_bist;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  op;
    logic [7:0]  a;
    logic [3:0]  fault_inj;
    logic        start;
    logic [3:0]  y;
    logic        busy, done;
    logic [15:0] test_count, error_count;

    logic [1:0]  op2;
    logic [5:0]  a2;
    logic [1:0]  fault_inj2;
    logic        start2;
    logic [1:0]  y2;
    logic        busy2, done2;
    logic [15:0] test_count2, error_count2;

    int pass_cnt = 0;
    int total_cnt = 0;
    int sb[$];

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [3:0] f;
        logic [3:0] exp_y;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    gate_array_bist dut (
        .clk(clk), .rst(rst), .op(op), .a(a), .fault_inj(fault_inj), .start(start),
        .y(y), .busy(busy), .done(done), .test_count(test_count), .error_count(error_count)
    );

    gate_array_bist #(.CH(2), .K(3)) dut2 (
        .clk(clk), .rst(rst), .op(op2), .a(a2), .fault_inj(fault_inj2), .start(start2),
        .y(y2), .busy(busy2), .done(done2), .test_count(test_count2), .error_count(error_count2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic sel_busy(input int which);
        return (which == 0) ? busy : busy2;
    endfunction

    task automatic run_table();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            op = tbl[i].op; a = tbl[i].a; fault_inj = tbl[i].f;
            sb.push_back(int'(tbl[i].exp_y));
            @(posedge clk); #1;
            chk($sformatf("func_y[%0d]", i), int'(y), sb.pop_front());
        end
        @(negedge clk);
        fault_inj = '0;
    endtask

    // Runs one self-test; op/a are scrambled mid-test and an optional second start is injected.
    task automatic run_st(input int which, input logic [1:0] opv, input int restart_at,
                          input int exp_cyc, input int exp_tc, input int exp_ec, input string nm);
        int cyc;
        @(negedge clk);
        if (which == 0) begin op = opv; start = 1'b1; end
        else begin op2 = opv; start2 = 1'b1; end
        sb.push_back(exp_cyc); sb.push_back(exp_tc); sb.push_back(exp_ec);
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0;
        chk({nm, "_done_low"}, int'((which == 0) ? done : done2), 0);
        cyc = 0;
        while (sel_busy(which) && cyc < 500) begin
            cyc++;
            if (cyc == 8) begin op = ~op; a = ~a; op2 = ~op2; a2 = ~a2; end
            start  = (which == 0) && (cyc == restart_at);
            start2 = (which == 1) && (cyc == restart_at);
            @(posedge clk); #1;
        end
        start = 1'b0; start2 = 1'b0;
        chk({nm, "_busy_cycles"}, cyc, sb.pop_front());
        chk({nm, "_done"}, int'((which == 0) ? done : done2), 1);
        chk({nm, "_test_count"}, int'((which == 0) ? test_count : test_count2), sb.pop_front());
        chk({nm, "_error_count"}, int'((which == 0) ? error_count : error_count2), sb.pop_front());
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_done_sticky"}, int'((which == 0) ? done : done2), 1);
        chk({nm, "_count_hold"}, int'((which == 0) ? test_count : test_count2), exp_tc);
    endtask

    initial begin
        tbl[0] = '{2'b11, 8'b00_01_10_00, 4'b0000, 4'b1001};
        tbl[1] = '{2'b10, 8'b00_01_10_00, 4'b0000, 4'b0110};
        tbl[2] = '{2'b00, 8'hFF,          4'b0000, 4'b1111};
        tbl[3] = '{2'b01, 8'hFF,          4'b0000, 4'b0000};
        tbl[4] = '{2'b00, 8'b11_01_11_10, 4'b0000, 4'b1010};
        tbl[5] = '{2'b10, 8'h00,          4'b0101, 4'b0101};
        tbl[6] = '{2'b11, 8'h00,          4'b1111, 4'b0000};
        tbl[7] = '{2'b01, 8'b00_11_01_11, 4'b0000, 4'b1010};

        rst = 1'b1; op = '0; a = '0; fault_inj = '0; start = 1'b0;
        op2 = '0; a2 = '0; fault_inj2 = 2'b11; start2 = 1'b0;
        #12;
        chk("rst_y", int'(y), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_test_count", int'(test_count), 0);
        chk("rst_error_count", int'(error_count), 0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_rst", int'(busy), 0);

        run_table();

        run_st(0, 2'b00, 0, 32, 16, 0, "st_and");
        @(negedge clk); fault_inj = 4'b0100;
        run_st(0, 2'b01, 0, 32, 16, 4, "st_nand_fault");
        @(negedge clk); fault_inj = 4'b0000;
        run_st(0, 2'b00, 5, 32, 16, 0, "st_restart_ignored");

        // Mid-test reset: asynchronous, checked before any further clock edge.
        @(negedge clk); op = 2'b10; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_test_count", int'(test_count), 0);
        chk("abort_error_count", int'(error_count), 0);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_stays_idle", int'(busy), 0);
        run_st(0, 2'b10, 0, 32, 16, 0, "st_after_abort");

        run_st(1, 2'b00, 0, 32, 16, 16, "st_ch2_k3_fault");

        run_table();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
